// File: rtl/th_fre_pkg.sv
// Shared types and constants for the theoretical-frequency sequencer.
package th_fre_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        SCALE,
        CONV,
        DONE
    } state_t;

    // Largest value that fits in the displayed digits: 10^digits - 1.
    function automatic int unsigned sat_limit(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one bit per cycle, BIN_W cycles after load.
// done is high during the final iteration; bcd holds the full result from the next cycle on.
module bin_to_bcd_seq
    import th_fre_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                      signal,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [BIN_W-1:0]          bin,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      done
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BW    = BCD_W * DIGITS;

    logic [BIN_W-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic [BW-1:0]    adj;

    always_comb begin
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[d*BCD_W +: BCD_W] >= BCD_W'(5)) begin
                adj[d*BCD_W +: BCD_W] = bcd[d*BCD_W +: BCD_W] + BCD_W'(3);
            end
        end
    end

    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
            run <= 1'b0;
            bcd <= '0;
        end else if (load) begin
            sh  <= bin;
            cnt <= '0;
            run <= 1'b1;
            bcd <= '0;
        end else if (run) begin
            // Adjust digits, then shift the next binary MSB into the BCD LSB.
            {bcd, sh} <= {adj[BW-2:0], sh, 1'b0};
            cnt       <= cnt + 1'b1;
            if (cnt == CNT_W'(BIN_W - 1)) begin
                run <= 1'b0;
            end
        end
    end

    assign done = run && (cnt == CNT_W'(BIN_W - 1));

endmodule

// File: rtl/th_fre_seq.sv
// Computes k*FCLK/2^ACC_W, clamps to DIGITS, converts to BCD; K_W+BIN_W+2 cycles per run.
// TH_FRE_ROUND_EN: round half-up instead of truncating in SCALE (same latency).
module th_fre_seq
    import th_fre_pkg::*;
#(
    parameter int K_W    = 8,
    parameter int ACC_W  = 8,
    parameter int FCLK   = 10000,
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                      signal,
    input  logic                      rst_n,
    input  logic [K_W-1:0]            k,
    input  logic                      start,
    output logic [BIN_W-1:0]          bin,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      valid,
    output logic                      busy,
    output logic                      ovf
);

    localparam int          P_W    = K_W + $clog2(FCLK + 1);
    localparam int          CNT_W  = $clog2(K_W + 1);
    localparam int unsigned LIMIT  = sat_limit(DIGITS);
    localparam logic [P_W:0]   LIM_P  = (P_W + 1)'(LIMIT);
    localparam logic [P_W-1:0] FCLK_P = P_W'(FCLK);
`ifdef TH_FRE_ROUND_EN
    localparam logic [P_W:0]   RND    = (P_W + 1)'(1) << (ACC_W - 1);
`else
    localparam logic [P_W:0]   RND    = '0;
`endif

    state_t                    state, state_nx;
    logic [K_W-1:0]            k_q;
    logic [K_W-1:0]            mk;
    logic [P_W-1:0]            prod;
    logic [CNT_W-1:0]          cnt;
    logic [BIN_W-1:0]          res_q;
    logic                      ovf_q;
    logic [P_W:0]              sum;
    logic [P_W:0]              scaled;
    logic [BIN_W-1:0]          clamp;
    logic                      ovf_next;
    logic                      accept;
    logic                      load;
    logic                      conv_done;
    logic [BCD_W*DIGITS-1:0]   bcd_w;

    assign accept = (state == IDLE) && (start || (k != k_q));

    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = MUL;
            MUL:     if (cnt == CNT_W'(K_W - 1)) state_nx = SCALE;
            SCALE:   state_nx = CONV;
            CONV:    if (conv_done) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        load = (state == SCALE);
    end

    always_comb begin
        sum    = {1'b0, prod} + RND;
        scaled = sum >> ACC_W;
        if (scaled > LIM_P) begin
            clamp    = BIN_W'(LIMIT);
            ovf_next = 1'b1;
        end else begin
            clamp    = scaled[BIN_W-1:0];
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= '0;
            mk    <= '0;
            prod  <= '0;
            cnt   <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            bin   <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        k_q  <= k;
                        mk   <= k;
                        prod <= '0;
                        cnt  <= '0;
                    end
                end
                MUL: begin
                    // MSB-first shift-add keeps the addend a constant FCLK.
                    prod <= (prod << 1) + (mk[K_W-1] ? FCLK_P : '0);
                    mk   <= mk << 1;
                    cnt  <= cnt + 1'b1;
                end
                SCALE: begin
                    res_q <= clamp;
                    ovf_q <= ovf_next;
                end
                DONE: begin
                    bin   <= res_q;
                    bcd   <= bcd_w;
                    ovf   <= ovf_q;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    bin_to_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .signal (signal),
        .rst_n  (rst_n),
        .load   (load),
        .bin    (clamp),
        .bcd    (bcd_w),
        .done   (conv_done)
    );

endmodule

// File: tb/tb_th_fre_seq.sv
// Scoreboard bench: two instances (FCLK 10000 and 20000) with directed runs.
module tb_th_fre_seq;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [7:0]  k_a, k_b;
    logic        start_a, start_b;
    logic [13:0] bin_a, bin_b;
    logic [15:0] bcd_a, bcd_b;
    logic        valid_a, valid_b, busy_a, busy_b, ovf_a, ovf_b;

    always #5 clk = ~clk;

    th_fre_seq #(.K_W(8), .ACC_W(8), .FCLK(10000), .DIGITS(4), .BIN_W(14)) dut_a (
        .signal(clk), .rst_n(rst_a), .k(k_a), .start(start_a),
        .bin(bin_a), .bcd(bcd_a), .valid(valid_a), .busy(busy_a), .ovf(ovf_a)
    );

    th_fre_seq #(.K_W(8), .ACC_W(8), .FCLK(20000), .DIGITS(4), .BIN_W(14)) dut_b (
        .signal(clk), .rst_n(rst_b), .k(k_b), .start(start_b),
        .bin(bin_b), .bcd(bcd_b), .valid(valid_b), .busy(busy_b), .ovf(ovf_b)
    );

    typedef struct packed {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   fin   = 1'b0;

`ifdef TH_FRE_ROUND_EN
    localparam logic [13:0] B255 = 14'd9961;
    localparam logic [15:0] D255 = 16'h9961;
    localparam logic [13:0] B200 = 14'd7813;
    localparam logic [15:0] D200 = 16'h7813;
`else
    localparam logic [13:0] B255 = 14'd9960;
    localparam logic [15:0] D255 = 16'h9960;
    localparam logic [13:0] B200 = 14'd7812;
    localparam logic [15:0] D200 = 16'h7812;
`endif

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops expected results on valid, checks reset values and output hold.
    initial begin
        exp_t e;
        exp_t hold_a;
        exp_t hold_b;
        bit   fin_done;
        hold_a   = '0;
        hold_b   = '0;
        fin_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                chk("a_reset_outputs", 64'({bin_a, bcd_a, valid_a, busy_a, ovf_a}), 64'(0));
                hold_a = '0;
            end else if (valid_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_valid", 64'(1), 64'(0));
                end else begin
                    e = q_a.pop_front();
                    chk("a_bin", 64'(bin_a), 64'(e.bin));
                    chk("a_bcd", 64'(bcd_a), 64'(e.bcd));
                    chk("a_ovf", 64'(ovf_a), 64'(e.ovf));
                    chk("a_latency_cycle", 64'(cyc), 64'(e.cyc));
                    chk("a_busy_at_valid", 64'(busy_a), 64'(0));
                    hold_a = e;
                end
            end else begin
                chk("a_hold", 64'({bin_a, bcd_a, ovf_a}), 64'({hold_a.bin, hold_a.bcd, hold_a.ovf}));
            end

            if (!rst_b) begin
                chk("b_reset_outputs", 64'({bin_b, bcd_b, valid_b, busy_b, ovf_b}), 64'(0));
                hold_b = '0;
            end else if (valid_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_valid", 64'(1), 64'(0));
                end else begin
                    e = q_b.pop_front();
                    chk("b_bin", 64'(bin_b), 64'(e.bin));
                    chk("b_bcd", 64'(bcd_b), 64'(e.bcd));
                    chk("b_ovf", 64'(ovf_b), 64'(e.ovf));
                    chk("b_latency_cycle", 64'(cyc), 64'(e.cyc));
                    hold_b = e;
                end
            end else begin
                chk("b_hold", 64'({bin_b, bcd_b, ovf_b}), 64'({hold_b.bin, hold_b.bcd, hold_b.ovf}));
            end

            if (fin && !fin_done) begin
                chk("a_missing_results", 64'(q_a.size()), 64'(0));
                chk("b_missing_results", 64'(q_b.size()), 64'(0));
                fin_done = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic exp_a(input logic [13:0] b, input logic [15:0] d, input logic o, input int c);
        exp_t e;
        e.bin = b; e.bcd = d; e.ovf = o; e.cyc = c;
        q_a.push_back(e);
    endtask

    task automatic exp_b(input logic [13:0] b, input logic [15:0] d, input logic o, input int c);
        exp_t e;
        e.bin = b; e.bcd = d; e.ovf = o; e.cyc = c;
        q_b.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (q_a.size() != 0 || q_b.size() != 0); i++) tick(1);
        tick(3);
    endtask

    // Accept happens on the edge after a change, so valid is seen at cyc+25.
    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        k_a = 8'd0; k_b = 8'd0;
        start_a = 1'b0; start_b = 1'b0;
        tick(3);
        rst_b = 1'b1;
        k_a   = 8'd128;
        tick(2);
        rst_a = 1'b1;
        exp_a(14'd5000, 16'h5000, 1'b0, cyc + 25);
        drain(100);

        k_a = 8'd255; exp_a(B255, D255, 1'b0, cyc + 25); drain(100);
        k_a = 8'd1;   exp_a(14'd39, 16'h0039, 1'b0, cyc + 25); drain(100);
        k_a = 8'd0;   exp_a(14'd0, 16'h0000, 1'b0, cyc + 25); drain(100);

        start_a = 1'b1; exp_a(14'd0, 16'h0000, 1'b0, cyc + 25);
        tick(1);
        start_a = 1'b0;
        drain(100);

        k_a = 8'd64;
        exp_a(14'd2500, 16'h2500, 1'b0, cyc + 25);
        exp_a(14'd7500, 16'h7500, 1'b0, cyc + 50);
        tick(5);
        k_a = 8'd192; start_a = 1'b1;
        tick(2);
        start_a = 1'b0;
        tick(8);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        drain(150);
        tick(40);

        k_a = 8'd200;
        tick(12);
        rst_a = 1'b0;
        tick(3);
        rst_a = 1'b1;
        exp_a(B200, D200, 1'b0, cyc + 25);
        drain(100);

        k_b = 8'd255; exp_b(14'd9999, 16'h9999, 1'b1, cyc + 25); drain(100);
        k_b = 8'd10;  exp_b(14'd781, 16'h0781, 1'b0, cyc + 25); drain(100);
        tick(30);

        fin = 1'b1;
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/th_fre_seq.md
TH_FRE_SEQ -- requirements
Module: th_fre_seq

Interface
REQ-001 SHALL have parameter K_W, default 8: width of tuning word k.
REQ-002 SHALL have parameter ACC_W, default 8: phase-accumulator width; result = k*FCLK/2^ACC_W.
REQ-003 SHALL have parameter FCLK, default 10000: reference clock in Hz.
REQ-004 SHALL have parameter DIGITS, default 4: BCD digits shown.
REQ-005 SHALL have parameter BIN_W, default 14: result binary width, at least clog2(10^DIGITS).
REQ-006 SHALL have port signal, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port k, input, K_W bits: switch tuning word, quasi-static.
REQ-009 SHALL have port start, input, 1 bit: request recompute, level-sampled.
REQ-010 SHALL have port bin, output, BIN_W bits: theoretical frequency in binary.
REQ-011 SHALL have port bcd, output, 4*DIGITS bits: same value in BCD, digit 0 in LSBs.
REQ-012 SHALL have port valid, output, 1 bit: one-cycle pulse when bin/bcd update.
REQ-013 SHALL have port busy, output, 1 bit: high while a computation runs.
REQ-014 SHALL have port ovf, output, 1 bit: last result saturated.

Function
REQ-015 SHALL use states IDLE, MUL, SCALE, CONV and DONE.
REQ-016 In IDLE, when start=1 or k differs from internal k_q, SHALL latch k into k_q, set busy and enter MUL.
REQ-017 MUL SHALL do shift-add multiply of k_q by FCLK, one bit per cycle, over exactly K_W cycles.
REQ-018 SCALE SHALL take 1 cycle: shift the product right by ACC_W and truncate; clamp to 10^DIGITS-1 with ovf_next=1 if larger.
REQ-019 CONV SHALL run double-dabble in sub-module bin_to_bcd_seq over exactly BIN_W cycles.
REQ-020 DONE SHALL take 1 cycle: load bin, bcd and ovf together, pulse valid, clear busy, return to IDLE.
REQ-021 Latency from the IDLE accept edge to the valid pulse SHALL be K_W+BIN_W+2 cycles, which is 24 at defaults.
REQ-022 bin, bcd and ovf SHALL hold stable between valid pulses.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 A change of k while busy=1 SHALL NOT corrupt the running computation; it is picked up by the k != k_q check in the IDLE cycle after DONE.
REQ-025 k=0 SHALL give bin=0, bcd=0, ovf=0.
REQ-026 Intermediate product width SHALL be K_W+clog2(FCLK+1) bits, with no internal overflow.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, with bin=0, bcd=0, valid=0, busy=0, ovf=0, k_q=0 and datapath registers 0.
REQ-028 Reset mid-computation SHALL abort it with no valid pulse; after release, a nonzero k SHALL trigger computation automatically via REQ-016.

Configuration
REQ-029 With macro TH_FRE_ROUND_EN defined, SCALE SHALL round half-up: add 2^(ACC_W-1) before the shift, then clamp.
REQ-030 Without TH_FRE_ROUND_EN, SCALE SHALL truncate.
REQ-031 Latency SHALL be identical with and without TH_FRE_ROUND_EN.

Structure
REQ-032 Package th_fre_pkg SHALL hold the state enum, the BCD digit width constant 4, and the function computing the saturation limit 10^DIGITS-1.
REQ-033 Sub-module bin_to_bcd_seq (BIN_W, DIGITS; ports signal, rst_n, load, bin, bcd, done) SHALL implement the iterative double-dabble; everything else stays in th_fre_seq.

Verification
REQ-034 Reset release with k=8'd128 and defaults -> valid pulses 24 cycles after the accept edge; bin=5000, bcd=16'h5000, ovf=0.
REQ-035 k=8'd255, truncate -> bin=9960, bcd=16'h9960; with TH_FRE_ROUND_EN -> bin=9961, bcd=16'h9961.
REQ-036 k=8'd1 -> bin=39, bcd=16'h0039; k=8'd0 -> bin=0, bcd=16'h0000.
REQ-037 FCLK=20000, k=8'd255 -> bin=9999, bcd=16'h9999, ovf=1; then k=8'd10 -> bin=781, ovf=0.
REQ-038 k changed 64->192 at cycle 5 of a run, plus start pulses while busy -> first valid shows 2500, a second run follows, then a valid showing 7500; no extra runs.
REQ-039 rst_n asserted at cycle 12 of a run -> no valid pulse, all outputs 0 immediately; after release the run restarts and completes with the correct value.
